// File: rtl/r2p_sched_pkg.sv
// Shared state encoding and default widths for the r2p round-robin scheduler.
package r2p_sched_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int NCH_D = 4;
  localparam int DSZ_D = 16;
  localparam int PSZ_D = 16;
  localparam int CHW_D = 2;
  localparam int TMO_D = 63;
endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin priority encoder: first requester after ptr wins.
module rr_arb #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [CHW-1:0] gnt,
  output logic           any
);
  logic [CHW-1:0] idx;
  logic           found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    any   = |req;
    for (int i = 0; i < NCH; i++) begin
      idx = (idx == CHW'(NCH-1)) ? '0 : idx + CHW'(1);
      if (req[idx] && !found) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/r2p_sched.sv
// Round-robin scheduler sharing one r2p CORDIC core among NCH channels.
// Optional watchdog on the core response: define R2P_SCHED_WDOG_EN.
module r2p_sched
  import r2p_sched_pkg::*;
#(
  parameter int NCH = NCH_D,
  parameter int DSZ = DSZ_D,
  parameter int PSZ = PSZ_D,
  parameter int CHW = CHW_D,
  parameter int TMO = TMO_D
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NCH-1:0]     req,
  input  logic [NCH*DSZ-1:0] x_in,
  input  logic [NCH*DSZ-1:0] y_in,
  output logic [NCH-1:0]     ack,
  output logic               core_ena,
  output logic [DSZ-1:0]     core_x,
  output logic [DSZ-1:0]     core_y,
  input  logic               core_valid,
  input  logic [DSZ-1:0]     core_mag,
  input  logic [PSZ-1:0]     core_angle,
  output logic               res_valid,
  output logic [CHW-1:0]     res_ch,
  output logic [DSZ-1:0]     res_mag,
  output logic [PSZ-1:0]     res_angle,
  output logic               busy,
  output logic               err
);
  state_t         state;
  logic [CHW-1:0] ptr, gch, gnt;
  logic           any;
  logic           wd_fire;

  rr_arb #(.NCH(NCH), .CHW(CHW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .any (any)
  );

`ifdef R2P_SCHED_WDOG_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] wcnt;
  logic          err_q;

  // wcnt is 0 on the first WAIT cycle, so the fire lands after exactly TMO WAIT cycles
  assign wd_fire = (state == WAIT) && !core_valid && (wcnt == CW'(TMO - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      wcnt <= (state == WAIT) ? wcnt + CW'(1) : '0;
      if (wd_fire) err_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= CHW'(NCH - 1);
      gch       <= '0;
      ack       <= '0;
      core_ena  <= 1'b0;
      core_x    <= '0;
      core_y    <= '0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_mag   <= '0;
      res_angle <= '0;
      busy      <= 1'b0;
    end else begin
      ack       <= '0;
      core_ena  <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: if (any) begin
          core_x <= x_in[int'(gnt)*DSZ +: DSZ];
          core_y <= y_in[int'(gnt)*DSZ +: DSZ];
          gch    <= gnt;
          ptr    <= gnt;
          ack    <= NCH'(1) << gnt;
          busy   <= 1'b1;
          state  <= ISSUE;
        end
        ISSUE: begin
          core_ena <= 1'b1;
          state    <= WAIT;
        end
        WAIT: if (core_valid) begin
          res_mag   <= core_mag;
          res_angle <= core_angle;
          res_ch    <= gch;
          res_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end else if (wd_fire) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_r2p_sched.sv
// Directed bench for r2p_sched with a behavioural stand-in for the r2p core.
module tb_r2p_sched;
  localparam int NCH = 4, DSZ = 16, PSZ = 16, CHW = 2, TMO = 63, LAT = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NCH-1:0]     req = '0;
  logic [NCH*DSZ-1:0] x_in = '0, y_in = '0;
  logic [NCH-1:0]     ack;
  logic               core_ena, core_valid;
  logic [DSZ-1:0]     core_x, core_y, core_mag;
  logic [PSZ-1:0]     core_angle;
  logic               res_valid, busy, err;
  logic [CHW-1:0]     res_ch;
  logic [DSZ-1:0]     res_mag;
  logic [PSZ-1:0]     res_angle;

  logic           model_vld = 1'b0, spur_vld = 1'b0, core_dead = 1'b0;
  logic [DSZ-1:0] model_mag = '0, spur_mag = '0;
  logic [PSZ-1:0] model_ang = '0, spur_ang = '0;

  assign core_valid = model_vld | spur_vld;
  assign core_mag   = spur_vld ? spur_mag : model_mag;
  assign core_angle = spur_vld ? spur_ang : model_ang;

  int n_chk = 0, n_bad = 0;
  int ack_cnt = 0, ack_bad = 0, ena_cnt = 0, ena_bad = 0;

  r2p_sched #(.NCH(NCH), .DSZ(DSZ), .PSZ(PSZ), .CHW(CHW), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .x_in(x_in), .y_in(y_in),
    .ack(ack), .core_ena(core_ena), .core_x(core_x), .core_y(core_y),
    .core_valid(core_valid), .core_mag(core_mag), .core_angle(core_angle),
    .res_valid(res_valid), .res_ch(res_ch), .res_mag(res_mag),
    .res_angle(res_angle), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // core stand-in: known CORDIC answers for the two test vectors, else mag=x+1, angle=y
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      model_vld = 1'b0;
      if (!reset_n) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && !core_dead) model_vld = 1'b1;
        end
        if (core_ena) begin
          cnt = LAT;
          if (core_x == 16'd3000 && core_y == 16'd4000) begin
            model_mag = 16'd5000; model_ang = 16'd9672;
          end else if (core_x == 16'hF448 && core_y == 16'hF060) begin
            model_mag = 16'd5000; model_ang = 16'd42440;
          end else begin
            model_mag = core_x + 16'd1; model_ang = core_y;
          end
        end
      end
    end
  end

  // ack/ena monitor: core_ena must follow an ack cycle directly
  initial begin
    logic ack_prev;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ack != '0) ack_cnt++;
      if ($countones(ack) > 1) ack_bad++;
      if (core_ena) begin
        ena_cnt++;
        if (!ack_prev) ena_bad++;
      end
      ack_prev = |ack;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [15:0] x, input logic [15:0] y);
    x_in[c*DSZ +: DSZ] = x;
    y_in[c*DSZ +: DSZ] = y;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset_n = 1'b0;
    @(negedge clk); @(negedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != '0) return;
    end
    chk("ack_timeout", 32'(ack != '0), 1);
  endtask

  task automatic wait_res();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) return;
    end
    chk("res_timeout", 32'(res_valid), 1);
  endtask

  task automatic single(input int c, input logic [15:0] x, input logic [15:0] mag,
                        input logic [15:0] ang);
    req = NCH'(1) << c;
    wait_ack();
    chk("ack_onehot", 32'(ack), 32'(NCH'(1) << c));
    req = '0;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 0);
    chk("ena_after_ack", 32'(core_ena), 1);
    chk("core_x", 32'(core_x), 32'(x));
    wait_res();
    chk("res_ch", 32'(res_ch), 32'(c));
    chk("res_mag", 32'(res_mag), 32'(mag));
    chk("res_angle", 32'(res_angle), 32'(ang));
    @(negedge clk);
    chk("res_valid_pulse", 32'(res_valid), 0);
  endtask

  initial begin
    int a0, e0, n;
    logic saw_rv;
    do_reset();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_ena", 32'(core_ena), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rv", 32'(res_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_data", {core_x, res_mag}, 0);

    set_ch(0, 16'd3000, 16'd4000);
    single(0, 16'd3000, 16'd5000, 16'd9672);
    set_ch(2, 16'hF448, 16'hF060);
    single(2, 16'hF448, 16'd5000, 16'd42440);

    // spurious strobe in IDLE
    spur_mag = 16'd1234; spur_ang = 16'd4321; spur_vld = 1'b1;
    @(negedge clk); spur_vld = 1'b0;
    @(negedge clk);
    chk("spur_rv", 32'(res_valid), 0);
    chk("spur_mag", 32'(res_mag), 5000);
    chk("spur_ang", 32'(res_angle), 42440);

    // all channels requesting continuously
    do_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, 16'(100*(c+1)), 16'(50+c));
    a0 = ack_cnt; e0 = ena_cnt;
    req = '1;
    for (int k = 0; k < 8; k++) begin
      wait_res();
      if (k == 7) req = '0;
      chk($sformatf("rr_ch%0d", k), 32'(res_ch), 32'(k % NCH));
      chk($sformatf("rr_mag%0d", k), 32'(res_mag), 32'(100*((k%NCH)+1)+1));
    end
    repeat (10) @(negedge clk);
    chk("rr_acks", 32'(ack_cnt - a0), 8);
    chk("rr_enas", 32'(ena_cnt - e0), 8);
    chk("ena_bad", 32'(ena_bad), 0);
    chk("ack_bad", 32'(ack_bad), 0);

    // reset in WAIT
    set_ch(3, 16'd900, 16'd9);
    req = 4'b1000;
    wait_ack(); req = '0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ena", 32'(core_ena), 0);
    chk("arst_data", {core_x, core_y}, 0);
    chk("arst_res", {res_mag, 13'd0, res_ch}, 0);
    @(negedge clk); #2 reset_n = 1'b1;
    set_ch(1, 16'd555, 16'd66);
    single(1, 16'd555, 16'd556, 16'd66);

`ifdef R2P_SCHED_WDOG_EN
    core_dead = 1'b1;
    set_ch(0, 16'd11, 16'd22);
    req = 4'b0001;
    wait_ack(); req = '0;
    n = 1; saw_rv = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      saw_rv |= res_valid;
      if (!busy) break;
      n++;
    end
    chk("wd_busy_len", 32'(n), TMO + 1);
    chk("wd_err", 32'(err), 1);
    chk("wd_no_rv", 32'(saw_rv), 0);
    core_dead = 1'b0;
    spur_vld = 1'b1; @(negedge clk); spur_vld = 1'b0;
    @(negedge clk);
    chk("wd_late_rv", 32'(res_valid), 0);
    set_ch(2, 16'd77, 16'd88);
    single(2, 16'd77, 16'd78, 16'd88);
    chk("wd_err_sticky", 32'(err), 1);
`else
    n = 0; saw_rv = 1'b0;
    chk("err_tied", 32'(err), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/r2p_sched.md
Name: r2p_sched

Overview:
Round-robin scheduler that shares one r2p CORDIC rectangular-to-polar core among NCH requesting channels (e.g. demodulated I/Q streams from the ADC front end). It captures one channel's (x,y) sample and issues a single-cycle ena to the core. It waits for the core's valid, then returns mag/angle tagged with the originating channel index. Only one conversion is in flight at a time.

Parameters:
NCH, 4, number of requesting channels (2..16)
DSZ, 16, x/y sample width; matches core dsz
PSZ, 16, angle width; matches core psz
CHW, 2, channel index width, must satisfy 2**CHW >= NCH
TMO, 63, watchdog limit in cycles for the core response (R2P_SCHED_WDOG_EN only)

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
req  in  NCH  per-channel request; level, held until ack
x_in  in  NCH*DSZ  signed x per channel, channel c at [c*DSZ +: DSZ]
y_in  in  NCH*DSZ  signed y per channel, same packing
ack  out  NCH  one-hot single-cycle pulse: sample taken, channel may drop/advance req
core_ena  out  1  single-cycle start to r2p
core_x  out  DSZ  held sample x to r2p
core_y  out  DSZ  held sample y to r2p
core_valid  in  1  r2p result strobe
core_mag  in  DSZ  r2p magnitude
core_angle  in  PSZ  r2p angle, 2^PSZ = 2*pi
res_valid  out  1  single-cycle result strobe
res_ch  out  CHW  channel of current result
res_mag  out  DSZ  registered magnitude
res_angle  out  PSZ  registered angle
busy  out  1  high in ISSUE or WAIT
err  out  1  sticky watchdog flag (R2P_SCHED_WDOG_EN only, else constant 0)

Behaviour:
- Reset (reset_n low, async): state IDLE; ack, core_ena, res_valid, busy, err = 0; core_x, core_y, res_mag, res_angle, res_ch = 0; rr pointer = NCH-1, so channel 0 wins first. The r2p core must be reset concurrently by the top level.
- IDLE: if any req, grant the first requesting channel after pointer (wrap NCH-1 -> 0). On that edge: latch core_x/core_y from the granted slice, set grant index, pointer = grant, ack[grant] = 1 for exactly one cycle, next state ISSUE. No req -> stay.
- ISSUE: core_ena = 1 for exactly this one cycle; next state WAIT.
- WAIT: on core_valid, register res_mag/res_angle/res_ch on that edge; res_valid = 1 the following cycle for one cycle; next state IDLE.
- Throughput: one conversion per (core latency + 3) cycles. An IDLE grant may occur in the same cycle res_valid is high.
- core_valid seen in IDLE or ISSUE is ignored; no result is produced.
- req dropped after ack has no effect on the running conversion. req still high after ack counts as a new request; the rr pointer ensures other requesters are served first.
- All req asserted continuously -> grants 0,1,..,NCH-1,0,... strictly.
- core_x/core_y stay stable from the latch until the next grant.
- Widths pass through unmodified; no arithmetic on data.

Optional Feature:
R2P_SCHED_WDOG_EN:
- Defined: a cycle counter runs in WAIT. If it reaches TMO without core_valid, the block returns to IDLE, sets err = 1 (sticky until reset), and produces no res_valid. A late core_valid afterwards is ignored.
- Undefined: no counter; WAIT holds indefinitely; err tied 0.

Decomposition:
- Package r2p_sched_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2) and the default width constants.
- One sub-module, rr_arb: combinational round-robin priority encoder. Inputs req vector and pointer; outputs grant index and any-request flag. Instantiated once.

Test Plan:
- Single req[0], x=3000, y=4000 -> ack[0] one cycle; core_ena one cycle later; res_ch=0, res_mag=5000±2, res_angle=9672±4.
- x=-3000, y=-4000 on channel 2 -> res_ch=2, res_mag=5000±2, res_angle=-23096±4 (i.e. 42440 unsigned).
- req=4'b1111 held for 8 conversions -> res_ch sequence 0,1,2,3,0,1,2,3; exactly one ack per conversion; core_ena never high while busy except in ISSUE.
- reset_n pulsed low during WAIT -> all outputs 0 asynchronously; after release, req[1] alone -> normal conversion, res_ch=1.
- With R2P_SCHED_WDOG_EN and core_valid forced 0 -> after TMO=63 WAIT cycles the block returns to IDLE with err=1 and no res_valid; the next request is still served.
- Spurious core_valid pulse in IDLE -> no res_valid; res_mag/res_angle unchanged.
